// File: rtl/fp_norm_pipe_pkg.sv
// Shared FPU normalizer definitions: default widths, clog2 helper and the
// zero/underflow flag layout consumed by the rounder.
package fp_norm_pipe_pkg;

  localparam int FP_MW = 32;
  localparam int FP_EW = 8;

  function automatic int fp_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef struct packed {
    logic zero;
    logic uflow;
  } norm_flags_t;

endpackage

// File: rtl/bsl.sv
// Logarithmic barrel shift-left over 2**SWIDTH bits with a constant filler bit.
module bsl #(
  parameter int   SWIDTH = 5,
  parameter logic FILLER = 1'b0,
  parameter int   DW     = 1 << SWIDTH
) (
  input  logic [DW-1:0]     din,
  input  logic [SWIDTH-1:0] sh,
  output logic [DW-1:0]     dout
);

  logic [SWIDTH:0][DW-1:0] stg;

  assign stg[0] = din;

  for (genvar i = 0; i < SWIDTH; i++) begin : g_stage
    localparam int S = 1 << i;
    assign stg[i+1] = sh[i] ? {stg[i][DW-1-S:0], {S{FILLER}}} : stg[i];
  end

  assign dout = stg[SWIDTH];

endmodule

// File: rtl/count_lead_zero.sv
// Leading-zero counter; an all-zero input reports W_IN-1.
module count_lead_zero #(
  parameter int W_IN = 32,
  parameter int LW   = $clog2(W_IN)
) (
  input  logic [W_IN-1:0] din,
  output logic [LW-1:0]   lz
);

  // Scan upward so the highest set bit is the last one to write lz.
  always_comb begin
    lz = LW'(W_IN - 1);
    for (int i = 0; i < W_IN; i++)
      if (din[i]) lz = LW'(W_IN - 1 - i);
  end

endmodule

// File: rtl/fp_norm_pipe.sv
// Post-add normalizer: two-stage valid/ready pipe (capture+lzc, shift+adjust).
// Optional saturating underflow counter under FP_NORM_UFLOW_CNT_EN.
module fp_norm_pipe
  import fp_norm_pipe_pkg::*;
#(
  parameter int MW = FP_MW,
  parameter int EW = FP_EW,
  parameter int LW = fp_clog2(MW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [MW-1:0] in_mant,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW-1:0] out_exp,
  output logic [MW-1:0] out_mant,
  output logic          out_zero,
  output logic          out_uflow
`ifdef FP_NORM_UFLOW_CNT_EN
  , output logic [15:0] uflow_cnt
`endif
);

  localparam int STAGES = 2;
  localparam int CW     = ((EW > LW) ? EW : LW) + 1;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
    logic [LW-1:0] lz;
  } s1_t;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
    norm_flags_t   flags;
  } s2_t;

  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;
  logic            s1_rdy, s2_rdy;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic [LW-1:0]   lz;
  logic [CW-1:0]   lz_ext, exp_ext;
  logic            use_exp;
  logic [LW-1:0]   sh_amt;
  logic [MW-1:0]   shifted;

  assign vld_pipe = {vld_q, in_valid};
  assign s2_rdy   = ~vld_pipe[2] | out_ready;
  assign s1_rdy   = ~vld_pipe[1] | s2_rdy;
  assign in_ready = s1_rdy;

  count_lead_zero #(.W_IN(MW), .LW(LW)) u_lzc (
    .din (in_mant),
    .lz  (lz)
  );

  assign s1_d = '{sign: in_sign, exp: in_exp, mant: in_mant, lz: lz};

  // Widen both operands so an exponent wider than the lz field compares correctly.
  assign lz_ext  = CW'(s1_q.lz);
  assign exp_ext = CW'(s1_q.exp);
  assign use_exp = ~(lz_ext < exp_ext);
  // On underflow exp <= lz < MW, so the truncated exponent is the exact shift.
  assign sh_amt  = use_exp ? LW'(s1_q.exp) : s1_q.lz;

  bsl #(.SWIDTH(LW), .FILLER(1'b0)) u_shift (
    .din  (s1_q.mant),
    .sh   (sh_amt),
    .dout (shifted)
  );

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    if (s1_q.mant == '0) begin
      s2_d.flags.zero = 1'b1;
    end else if (!use_exp) begin
      s2_d.mant = shifted;
      s2_d.exp  = EW'(exp_ext - lz_ext);
    end else begin
      s2_d.mant        = shifted;
      s2_d.flags.uflow = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      if (s1_rdy) vld_q[1] <= vld_pipe[0];
      if (s2_rdy) vld_q[2] <= vld_pipe[1];
      if (vld_pipe[0] && s1_rdy) s1_q <= s1_d;
      if (vld_pipe[1] && s2_rdy) s2_q <= s2_d;
    end
  end

  assign out_valid = vld_pipe[2];
  assign out_sign  = s2_q.sign;
  assign out_exp   = s2_q.exp;
  assign out_mant  = s2_q.mant;
  assign out_zero  = s2_q.flags.zero;
  assign out_uflow = s2_q.flags.uflow;

`ifdef FP_NORM_UFLOW_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      uflow_cnt <= '0;
    else if (out_valid && out_ready && out_uflow && (uflow_cnt != 16'hFFFF))
      uflow_cnt <= uflow_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Self-checking bench for fp_norm_pipe (MW=32, EW=8): directed table, burst,
// stall and reset sequences, then random traffic against a scoreboard model.
module tb_fp_norm_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [31:0] in_mant;
  logic        out_valid, out_ready, out_sign;
  logic [7:0]  out_exp;
  logic [31:0] out_mant;
  logic        out_zero, out_uflow;
`ifdef FP_NORM_UFLOW_CNT_EN
  logic [15:0] uflow_cnt;
`endif

  always #5 clk = ~clk;

  fp_norm_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
`ifdef FP_NORM_UFLOW_CNT_EN
    , .uflow_cnt (uflow_cnt)
`endif
  );

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [31:0] mant;
    logic        zero;
    logic        uflow;
  } res_t;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [31:0] mant;
    logic [7:0]  x_exp;
    logic [31:0] x_mant;
    logic        x_zero;
    logic        x_uflow;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_uflow = 0;
  res_t exp_q[$];
  logic stall_prev = 1'b0;
  res_t snap;
  logic saw_in, saw_out, saw_ovalid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Normalization rules evaluated arithmetically.
  function automatic res_t model(input logic s, input logic [7:0] e, input logic [31:0] m);
    res_t r;
    int   lz;
    r = '0;
    r.sign = s;
    if (m == 0) begin
      r.zero = 1'b1;
      return r;
    end
    lz = 0;
    while (m < (32'h8000_0000 >> lz)) lz++;
    if (lz < int'(e)) begin
      r.mant = m << lz;
      r.exp  = 8'(int'(e) - lz);
    end else begin
      r.mant  = m << e;
      r.uflow = 1'b1;
    end
    return r;
  endfunction

  function automatic res_t cur_out();
    return '{sign: out_sign, exp: out_exp, mant: out_mant, zero: out_zero, uflow: out_uflow};
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    res_t e;
    #1;
    if (stall_prev) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(cur_out()), 64'(snap));
    end
    saw_in     = in_valid && in_ready;
    saw_out    = out_valid && out_ready;
    saw_ovalid = out_valid;
    if (saw_in) exp_q.push_back(model(in_sign, in_exp, in_mant));
    if (saw_out) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(cur_out()), 64'd0);
        if (cur_out() == 0) begin n_fail++; $display("FAIL spurious_out: output with empty scoreboard"); end
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 64'(cur_out()), 64'(e));
      end
      if (out_uflow) n_uflow++;
    end
    stall_prev = out_valid && !out_ready;
    snap       = cur_out();
    @(negedge clk);
  endtask

  task automatic rand_in();
    in_sign = 1'($urandom);
    in_exp  = 8'($urandom_range(0, 255));
    in_mant = $urandom >> $urandom_range(0, 32);
  endtask

  vec_t vecs[9];
  int   lat, first, last, nout, nin, sent;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 8'd40,  32'h0000_1000, 8'd21,  32'h8000_0000, 0, 0};
    vecs[1] = '{1, 8'd90,  32'h0000_0000, 8'd0,   32'h0000_0000, 1, 0};
    vecs[2] = '{0, 8'd5,   32'h0000_00FF, 8'd0,   32'h0000_1FE0, 0, 1};
    vecs[3] = '{1, 8'd127, 32'h8000_0001, 8'd127, 32'h8000_0001, 0, 0};
    vecs[4] = '{0, 8'd31,  32'h0000_0001, 8'd0,   32'h8000_0000, 0, 1};
    vecs[5] = '{1, 8'd32,  32'h0000_0001, 8'd1,   32'h8000_0000, 0, 0};
    vecs[6] = '{0, 8'd0,   32'h4000_0000, 8'd0,   32'h4000_0000, 0, 1};
    vecs[7] = '{1, 8'd255, 32'h0000_0003, 8'd225, 32'hC000_0000, 0, 0};
    vecs[8] = '{1, 8'd0,   32'h0000_0000, 8'd0,   32'h0000_0000, 1, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_mant = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(cur_out()), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef FP_NORM_UFLOW_CNT_EN
    chk("rst_uflow_cnt", 64'(uflow_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, one beat at a time with out_ready high.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_sign = vecs[i].sign; in_exp = vecs[i].exp; in_mant = vecs[i].mant;
      #1 chk("tbl_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 5) begin @(posedge clk); #1; lat++; end
      chk("tbl_latency", 64'(lat), 64'd1);
      chk("tbl_sign", 64'(out_sign), 64'(vecs[i].sign));
      chk("tbl_exp", 64'(out_exp), 64'(vecs[i].x_exp));
      chk("tbl_mant", 64'(out_mant), 64'(vecs[i].x_mant));
      chk("tbl_zero", 64'(out_zero), 64'(vecs[i].x_zero));
      chk("tbl_uflow", 64'(out_uflow), 64'(vecs[i].x_uflow));
      n_uflow += int'(vecs[i].x_uflow);
      @(negedge clk);
    end
    @(negedge clk);
    chk("tbl_drained", 64'(out_valid), 64'd0);
`ifdef FP_NORM_UFLOW_CNT_EN
    chk("tbl_uflow_cnt", 64'(uflow_cnt), 64'(n_uflow));
`endif

    // Eight back-to-back beats must emerge on eight consecutive cycles.
    first = -1; last = -1; nout = 0; nin = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 8);
      in_sign = 1'b0; in_exp = 8'd127; in_mant = 32'h8000_0001 + 32'(c);
      step();
      if (saw_in) nin++;
      if (saw_out) begin if (first < 0) first = c; last = c; nout++; end
    end
    chk("burst_in", 64'(nin), 64'd8);
    chk("burst_out", 64'(nout), 64'd8);
    chk("burst_span", 64'(last - first), 64'd7);

    // Six beats with out_ready held low for the first three cycles.
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid  = (sent < 6);
      out_ready = (c >= 3);
      rand_in();
      step();
      if (c == 2) chk("stall_in_ready", 64'(saw_in), 64'd0);
      if (saw_in) sent++;
    end
    chk("stall_sent", 64'(sent), 64'd6);
    chk("stall_sb_empty", 64'(exp_q.size()), 64'd0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      rand_in();
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    chk("rand_sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef FP_NORM_UFLOW_CNT_EN
    chk("rand_uflow_cnt", 64'(uflow_cnt), 64'(n_uflow));
`endif

    // Reset with both stages full.
    out_ready = 1'b0; in_valid = 1'b1;
    rand_in(); step();
    rand_in(); step();
    in_valid = 1'b0;
    #1 chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    stall_prev = 1'b0;
    n_uflow = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("post_rst_no_stale", 64'(saw_ovalid), 64'd0);
    end
`ifdef FP_NORM_UFLOW_CNT_EN
    chk("post_rst_uflow_cnt", 64'(uflow_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
